audio_capture_writer: RTL and testbench

//  Records a fixed-length clip of audio from the codec input FIFO into a single-port sample RAM.

---
 rtl/audio_capture_writer_pkg.sv | 14 +
 rtl/audio_capture_writer_if.sv | 23 ++
 rtl/audio_capture_writer_stereo_mix.sv | 26 ++
 rtl/audio_capture_writer.sv | 108 ++++++++++
 tb/tb_audio_capture_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_capture_writer_pkg.sv
// rtl/audio_capture_writer_pkg.sv - shared types and constants for the audio clip recorder
package audio_pkg;

  typedef logic signed [23:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

  localparam int CLIP_DEPTH = 48000;

endpackage

// File: rtl/audio_capture_writer_if.sv
// rtl/audio_capture_writer_if.sv - codec read handshake and sample RAM write port
interface audio_capture_writer_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  read_ready, readdata_left, readdata_right,
    output read, wr_en, wr_addr, wr_data
  );

  modport slave (
    output read_ready, readdata_left, readdata_right,
    input  read, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/audio_capture_writer_stereo_mix.sv
// rtl/audio_capture_writer_stereo_mix.sv - left/right to mono sample; STEREO_AVG_EN selects averaging
module stereo_mix #(
  parameter int DATA_W = 24
) (
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic [DATA_W-1:0] sample
);

`ifdef STEREO_AVG_EN
  logic signed [DATA_W:0] sum;

  // One guard bit keeps the sum exact; dropping the LSB floors toward -inf.
  always_comb begin
    sum = $signed({left[DATA_W-1], left}) + $signed({right[DATA_W-1], right});
  end

  assign sample = sum[DATA_W:1];
`else
  logic unused_right;

  assign unused_right = ^right;
  assign sample       = left;
`endif

endmodule

// File: rtl/audio_capture_writer.sv
// rtl/audio_capture_writer.sv - records DEPTH codec samples into sequential RAM addresses, then flags done
module audio_capture_writer
  import audio_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = CLIP_DEPTH,
  parameter int ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   abort,
  audio_capture_writer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_MAX   = ADDR_W'(DEPTH);

  cap_state_t        state;
  cap_state_t        state_next;
  logic              pop;
  logic              start;
  logic [DATA_W-1:0] sample;

  stereo_mix #(
    .DATA_W(DATA_W)
  ) u_mix (
    .left  (bus.readdata_left),
    .right (bus.readdata_right),
    .sample(sample)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort outranks arm everywhere, and also suppresses the pop in its cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && arm) begin
          state_next = CAPTURE;
          start      = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (bus.read_ready) begin
          pop = 1'b1;
          if (count == LAST_ADDR) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (arm) begin
          state_next = CAPTURE;
          start      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.read = pop;
  assign busy     = (state == CAPTURE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      done        <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= pop;
      if (pop) begin
        bus.wr_addr <= count;
        bus.wr_data <= sample;
      end
      if (start) begin
        count <= '0;
        done  <= 1'b0;
      end else begin
        if (pop && count != CNT_MAX) begin
          count <= count + 1'b1;
        end
        if (pop && count == LAST_ADDR) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_capture_writer.sv
// tb/tb_audio_capture_writer.sv - scoreboard bench for audio_capture_writer; expectations follow STEREO_AVG_EN
module tb_audio_capture_writer;
  import audio_pkg::*;

  localparam int DW  = 24;
  localparam int DEP = 8;
  localparam int AW  = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm     = 1'b0;
  logic          abort   = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] count;

  audio_capture_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  audio_capture_writer #(
    .DATA_W(DW),
    .DEPTH (DEP),
    .ADDR_W(AW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .arm    (arm),
    .abort  (abort),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every RAM write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic pop(input logic [DW-1:0] l, input logic [DW-1:0] r,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.read_ready     = 1'b1;
    bus.readdata_left  = l;
    bus.readdata_right = r;
    sb.push_back(wr_t'{a, d});
    @(negedge clock);
    chk("read_on_pop", 32'(bus.read), 32'd1);
    step();
    bus.read_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_count"},   32'(count),       32'd0);
    chk({tag, "_done"},    32'(done),        32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_read"},    32'(bus.read),    32'd0);
  endtask

  logic [DW-1:0] exp_avg_a;
  logic [DW-1:0] exp_avg_b;

  initial begin
`ifdef STEREO_AVG_EN
    exp_avg_a = 24'h400000;
    exp_avg_b = 24'hFFFFFE;
`else
    exp_avg_a = 24'h7FFFFF;
    exp_avg_b = 24'hFFFFFD;
`endif
    bus.read_ready     = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;

    repeat (2) step();
    check_reset_outputs("por");
    reset_n = 1'b1;
    step();

    // Reset in the middle of a capture
    do_arm();
    pop(24'd1, 24'd1, 4'd0, 24'd1);
    pop(24'd2, 24'd2, 4'd1, 24'd2);
    step();
    bus.read_ready    = 1'b1;
    bus.readdata_left = 24'd3;
    #1;
    chk("mid_read_before_reset", 32'(bus.read), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("post_rst_busy",  32'(busy),      32'd0);
      step();
    end
    bus.read_ready = 1'b0;

    // Full back-to-back clip
    do_arm();
    @(negedge clock);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_count0", 32'(count), 32'd0);
    step();
    for (int i = 0; i < DEP; i++) begin
      bus.read_ready     = 1'b1;
      bus.readdata_left  = DW'(i);
      bus.readdata_right = DW'(i);
      sb.push_back(wr_t'{AW'(i), DW'(i)});
      @(negedge clock);
      chk("t2_read", 32'(bus.read), 32'd1);
      chk("t2_wr_en_lag", 32'(bus.wr_en), (i != 0) ? 32'd1 : 32'd0);
      step();
    end
    @(negedge clock);
    chk("t2_no_9th_read", 32'(bus.read), 32'd0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_busy_low", 32'(busy), 32'd0);
    step();
    bus.read_ready = 1'b0;
    step();

    // Intermittent read_ready
    do_arm();
    @(negedge clock);
    chk("t3_count0", 32'(count), 32'd0);
    chk("t3_done0", 32'(done), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      pop(DW'(10 + k), DW'(10 + k), AW'(k), DW'(10 + k));
      @(negedge clock);
      chk("t3_idle_read", 32'(bus.read), 32'd0);
      step();
    end
    do_abort();
    @(negedge clock);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_done", 32'(done), 32'd0);
    step();

    // Abort after three pops, then restart at address 0
    do_arm();
    pop(24'd20, 24'd20, 4'd0, 24'd20);
    pop(24'd21, 24'd21, 4'd1, 24'd21);
    pop(24'd22, 24'd22, 4'd2, 24'd22);
    bus.read_ready = 1'b1;
    abort          = 1'b1;
    @(negedge clock);
    chk("t4_abort_read", 32'(bus.read), 32'd0);
    step();
    abort          = 1'b0;
    bus.read_ready = 1'b0;
    @(negedge clock);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_count", 32'(count), 32'd3);
    chk("t4_done", 32'(done), 32'd0);
    step();
    do_arm();
    pop(24'd30, 24'd30, 4'd0, 24'd30);
    do_abort();

    // arm+abort together stay idle; held arm re-arms through DONE
    arm   = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    arm   = 1'b0;
    @(negedge clock);
    chk("t5_stay_idle", 32'(busy), 32'd0);
    step();
    arm = 1'b1;
    step();
    for (int i = 0; i < DEP; i++) begin
      pop(DW'(40 + i), DW'(40 + i), AW'(i), DW'(40 + i));
    end
    @(negedge clock);
    chk("t5_done", 32'(done), 32'd1);
    step();
    @(negedge clock);
    chk("t5_rearm_busy", 32'(busy), 32'd1);
    chk("t5_rearm_count", 32'(count), 32'd0);
    chk("t5_rearm_done", 32'(done), 32'd0);
    arm = 1'b0;
    step();
    do_abort();

    // Stereo mix corner values
    do_arm();
    pop(24'h7FFFFF, 24'h000001, 4'd0, exp_avg_a);
    pop(24'hFFFFFD, 24'h000000, 4'd1, exp_avg_b);
    do_abort();
    repeat (3) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
